// File: rtl/sisc_exec_ctrl_if.sv
// Datapath-facing bundle of the SISC execution core: instruction, operands, status and PC
// inputs, plus ALU, condition-code, register-file and PC control outputs.
interface sisc_exec_ctrl_if;
    logic [31:0] INSTR;
    logic [31:0] RSA;
    logic [31:0] RSB;
    logic [3:0]  STAT;
    logic [15:0] PC_INC;
    logic [31:0] ALU_RESULT;
    logic [3:0]  CC;
    logic        STAT_EN;
    logic [1:0]  ALU_OP;
    logic        RF_WE;
    logic        WB_SEL;
    logic        RD_SEL;
    logic        PC_WRITE;
    logic        PC_SEL;
    logic        PC_RST;
    logic        BR_SEL;
    logic [15:0] BR_ADDR;

    modport master (
        output INSTR, RSA, RSB, STAT, PC_INC,
        input  ALU_RESULT, CC, STAT_EN, ALU_OP, RF_WE, WB_SEL, RD_SEL,
               PC_WRITE, PC_SEL, PC_RST, BR_SEL, BR_ADDR
    );

    modport slave (
        input  INSTR, RSA, RSB, STAT, PC_INC,
        output ALU_RESULT, CC, STAT_EN, ALU_OP, RF_WE, WB_SEL, RD_SEL,
               PC_WRITE, PC_SEL, PC_RST, BR_SEL, BR_ADDR
    );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// SISC execution core: multicycle control FSM, 32-bit ALU with condition codes,
// and branch-target generation, all decoded from the current instruction word.
module sisc_exec_ctrl (
    input  logic              CLK,
    input  logic              RST,
    sisc_exec_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]  w_opcode;
    logic [3:0]  w_mm;
    logic [15:0] w_imm;
    logic        w_is_reg;
    logic        w_is_imm;
    logic        w_is_alu;
    logic        w_is_bset;
    logic        w_is_bclr;
    logic        w_abs;
    logic        w_taken;
    logic [1:0]  w_alu_op_dec;
    logic        w_unused_ra_rb;

    logic        w_stat_en;
    logic [1:0]  w_alu_op;
    logic        w_rf_we;
    logic        w_wb_sel;
    logic        w_rd_sel;
    logic        w_pc_write;
    logic        w_pc_sel;
    logic        w_pc_rst;
    logic        w_br_sel;

    logic [31:0] w_b;
    logic [31:0] w_bx;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_c;
    logic        w_v;

    assign w_opcode = bus.INSTR[31:28];
    assign w_mm     = bus.INSTR[27:24];
    assign w_imm    = bus.INSTR[15:0];
    // Register addresses are consumed by the register file, not here.
    assign w_unused_ra_rb = ^bus.INSTR[23:16];

    assign w_is_reg     = (w_opcode == 4'b0001);
    assign w_is_imm     = (w_opcode == 4'b0010);
    assign w_is_alu     = w_is_reg | w_is_imm;
    assign w_is_bset    = (w_opcode == 4'b0100) | (w_opcode == 4'b0101);
    assign w_is_bclr    = (w_opcode == 4'b0110) | (w_opcode == 4'b0111);
    assign w_abs        = (w_opcode == 4'b0100) | (w_opcode == 4'b0110);
    assign w_taken      = (w_is_bset & (|(bus.STAT & w_mm))) |
                          (w_is_bclr & ~(|(bus.STAT & w_mm)));
    assign w_alu_op_dec = w_is_reg ? 2'b01 : (w_is_imm ? 2'b10 : 2'b00);

    // State register with synchronous reset into START.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        w_next     = r_state;
        w_stat_en  = 1'b0;
        w_alu_op   = 2'b00;
        w_rf_we    = 1'b0;
        w_wb_sel   = 1'b0;
        w_rd_sel   = 1'b0;
        w_pc_write = 1'b0;
        w_pc_sel   = 1'b0;
        w_pc_rst   = 1'b0;
        w_br_sel   = w_abs;
        case (r_state)
            ST_START: begin
                w_pc_rst = 1'b1;
                w_br_sel = 1'b0;
                w_next   = ST_FETCH;
            end
            ST_FETCH: begin
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_opcode == 4'b1111) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                w_alu_op  = w_alu_op_dec;
                w_stat_en = w_is_alu;
                w_next    = ST_MEM;
            end
            ST_MEM: begin
                w_alu_op = w_alu_op_dec;
                w_next   = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                w_alu_op   = w_alu_op_dec;
                w_pc_write = 1'b1;
                w_pc_sel   = w_taken;
                w_rf_we    = w_is_alu;
                w_wb_sel   = w_is_alu;
                w_rd_sel   = w_is_reg;
                w_next     = ST_FETCH;
            end
            ST_HALT: begin
                w_br_sel = 1'b0;
                w_next   = ST_HALT;
            end
            default: begin
                w_br_sel = 1'b0;
                w_next   = ST_START;
            end
        endcase
    end

    // SUB reuses the adder as A + ~B + 1 so carry and overflow fall out of one path.
    always_comb begin
        w_b   = (w_alu_op == 2'b10) ? {16'h0000, w_imm} : bus.RSB;
        w_bx  = w_b;
        w_cin = 1'b0;
        if ((w_alu_op == 2'b01 || w_alu_op == 2'b10) && w_mm == 4'b0010) begin
            w_bx  = ~w_b;
            w_cin = 1'b1;
        end else begin
            w_bx  = w_b;
            w_cin = 1'b0;
        end
        w_sum = {1'b0, bus.RSA} + {1'b0, w_bx} + {32'd0, w_cin};
    end

    // ALU function select and condition codes.
    always_comb begin
        w_result = bus.RSA;
        w_c      = 1'b0;
        w_v      = 1'b0;
        if (w_alu_op == 2'b01 || w_alu_op == 2'b10) begin
            case (w_mm)
                4'b0001, 4'b0010: begin
                    w_result = w_sum[31:0];
                    w_c      = w_sum[32];
                    w_v      = (bus.RSA[31] == w_bx[31]) && (w_sum[31] != bus.RSA[31]);
                end
                4'b0011: w_result = bus.RSA & w_b;
                4'b0100: w_result = bus.RSA | w_b;
                4'b0101: w_result = bus.RSA ^ w_b;
                4'b0110: w_result = ~bus.RSA;
                4'b0111: w_result = {bus.RSA[30:0], 1'b0};
                4'b1000: w_result = {1'b0, bus.RSA[31:1]};
                default: w_result = bus.RSA;
            endcase
        end else begin
            w_result = bus.RSA;
        end
    end

    assign bus.ALU_RESULT = w_result;
    assign bus.CC         = {w_c, w_v, w_result[31], (w_result == 32'd0)};
    assign bus.BR_ADDR    = w_br_sel ? w_imm : (bus.PC_INC + w_imm);

    assign bus.STAT_EN  = w_stat_en;
    assign bus.ALU_OP   = w_alu_op;
    assign bus.RF_WE    = w_rf_we;
    assign bus.WB_SEL   = w_wb_sel;
    assign bus.RD_SEL   = w_rd_sel;
    assign bus.PC_WRITE = w_pc_write;
    assign bus.PC_SEL   = w_pc_sel;
    assign bus.PC_RST   = w_pc_rst;
    assign bus.BR_SEL   = w_br_sel;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed bench for sisc_exec_ctrl: reset sequencing, ALU results/flags, immediate form,
// branch targets and conditions, halt, and reset out of halt and mid-instruction.
module tb_sisc_exec_ctrl;

    logic CLK;
    logic RST;
    int   vectors;
    int   errors;

    sisc_exec_ctrl_if bus ();

    sisc_exec_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control word: {PC_RST, STAT_EN, ALU_OP[1:0], RF_WE, WB_SEL, RD_SEL, PC_WRITE, PC_SEL, BR_SEL}
    function automatic logic [9:0] ctl();
        return {bus.PC_RST, bus.STAT_EN, bus.ALU_OP, bus.RF_WE, bus.WB_SEL,
                bus.RD_SEL, bus.PC_WRITE, bus.PC_SEL, bus.BR_SEL};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // From FETCH: load the instruction and operands, then advance to EXECUTE.
    task automatic to_exec(input logic [31:0] instr, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] stat,
                           input logic [15:0] pcinc);
        bus.INSTR  = instr;
        bus.RSA    = a;
        bus.RSB    = b;
        bus.STAT   = stat;
        bus.PC_INC = pcinc;
        step();
        step();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        RST     = 1'b1;
        bus.INSTR  = 32'h1112_3000;
        bus.RSA    = 32'h0000_04D2;
        bus.RSB    = 32'h0000_0000;
        bus.STAT   = 4'b0000;
        bus.PC_INC = 16'h0001;

        step();
        step();
        chk("reset_ctl", {22'd0, ctl()}, {22'd0, 10'b1000000000});
        RST = 1'b0;
        chk("start_ctl", {22'd0, ctl()}, {22'd0, 10'b1000000000});
        chk("aluop00_pass", bus.ALU_RESULT, 32'h0000_04D2);
        step();
        chk("fetch_ctl", {22'd0, ctl()}, 32'd0);
        step();
        chk("decode_ctl", {22'd0, ctl()}, 32'd0);
        step();
        chk("add_exec_ctl", {22'd0, ctl()}, {22'd0, 10'b0101000000});
        chk("add_result", bus.ALU_RESULT, 32'h0000_04D2);
        chk("add_cc", {28'd0, bus.CC}, {28'd0, 4'b0000});
        step();
        chk("add_mem_ctl", {22'd0, ctl()}, {22'd0, 10'b0001000000});
        step();
        chk("add_wb_ctl", {22'd0, ctl()}, {22'd0, 10'b0001111100});
        step();
        chk("wb_to_fetch", {22'd0, ctl()}, 32'd0);

        to_exec(32'h1212_3000, 32'd5, 32'd5, 4'b0000, 16'h0002);
        chk("sub_result", bus.ALU_RESULT, 32'h0000_0000);
        chk("sub_cc", {28'd0, bus.CC}, {28'd0, 4'b1001});
        step(); step();
        chk("sub_wb_ctl", {22'd0, ctl()}, {22'd0, 10'b0001111100});
        step();

        to_exec(32'h1112_3000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 16'h0003);
        chk("addovf_result", bus.ALU_RESULT, 32'h8000_0000);
        chk("addovf_cc", {28'd0, bus.CC}, {28'd0, 4'b0110});
        bus.RSA = 32'hFFFF_FFFF;
        bus.RSB = 32'h0000_0001;
        #1;
        chk("addcarry_result", bus.ALU_RESULT, 32'h0000_0000);
        chk("addcarry_cc", {28'd0, bus.CC}, {28'd0, 4'b1001});
        step(); step(); step();

        to_exec(32'h1312_3000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0000, 16'h0004);
        chk("and_result", bus.ALU_RESULT, 32'h8000_0000);
        chk("and_cc", {28'd0, bus.CC}, {28'd0, 4'b0010});
        step(); step(); step();

        to_exec(32'h1712_3000, 32'h8000_0001, 32'h0, 4'b0000, 16'h0005);
        chk("shl_result", bus.ALU_RESULT, 32'h0000_0002);
        chk("shl_cc", {28'd0, bus.CC}, {28'd0, 4'b0000});
        step(); step(); step();

        to_exec(32'h1812_3000, 32'h8000_0001, 32'h0, 4'b0000, 16'h0006);
        chk("shr_result", bus.ALU_RESULT, 32'h4000_0000);
        step(); step(); step();

        to_exec(32'h1512_3000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 16'h0007);
        chk("xor_result", bus.ALU_RESULT, 32'h0FF0_0FF0);
        step(); step(); step();

        to_exec(32'h2101_FFFF, 32'h0000_0001, 32'h1234_5678, 4'b0000, 16'h0008);
        chk("imm_exec_ctl", {22'd0, ctl()}, {22'd0, 10'b0110000000});
        chk("imm_result", bus.ALU_RESULT, 32'h0001_0000);
        step(); step();
        chk("imm_wb_ctl", {22'd0, ctl()}, {22'd0, 10'b0010110100});
        step();

        to_exec(32'h5100_FFF0, 32'h0, 32'h0, 4'b0001, 16'h0010);
        chk("brr_exec_ctl", {22'd0, ctl()}, 32'd0);
        chk("brr_addr", {16'd0, bus.BR_ADDR}, {16'd0, 16'h0000});
        step(); step();
        chk("brr_taken_wb", {22'd0, ctl()}, {22'd0, 10'b0000000110});
        step();

        to_exec(32'h5100_FFF0, 32'h0, 32'h0, 4'b0000, 16'h0010);
        step(); step();
        chk("brr_not_wb", {22'd0, ctl()}, {22'd0, 10'b0000000100});
        step();

        bus.INSTR = 32'h6100_0040;
        bus.STAT  = 4'b0000;
        step();
        chk("bne_decode_ctl", {22'd0, ctl()}, {22'd0, 10'b0000000001});
        step();
        chk("bne_addr", {16'd0, bus.BR_ADDR}, {16'd0, 16'h0040});
        step(); step();
        chk("bne_taken_wb", {22'd0, ctl()}, {22'd0, 10'b0000000111});
        bus.STAT = 4'b0001;
        #1;
        chk("bne_blocked_wb", {22'd0, ctl()}, {22'd0, 10'b0000000101});
        step();

        to_exec(32'hF000_0000, 32'h0, 32'h0, 4'b0000, 16'h0020);
        for (int i = 0; i < 20; i++) begin
            chk("halt_ctl", {22'd0, ctl()}, 32'd0);
            step();
        end
        RST = 1'b1;
        step();
        chk("halt_reset_ctl", {22'd0, ctl()}, {22'd0, 10'b1000000000});
        RST = 1'b0;
        step();
        to_exec(32'h1112_3000, 32'h1, 32'h1, 4'b0000, 16'h0001);
        chk("mid_exec_ctl", {22'd0, ctl()}, {22'd0, 10'b0101000000});
        step();
        RST = 1'b1;
        step();
        chk("mid_reset_ctl", {22'd0, ctl()}, {22'd0, 10'b1000000000});
        RST = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sisc_exec_ctrl.md
# sisc_exec_ctrl

This block is the SISC instruction-execution core: the multicycle control FSM, the 32-bit ALU and the branch-address generator merged into one unit. It sits between the instruction memory, register file, status register and PC. It decodes the current instruction word and drives all datapath controls. It computes the ALU result and condition codes, and it computes the branch target.

## Interface
- Parameters: none.
- CLK  in  1  sole clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- INSTR  in  32  instruction word from IM; fields: [31:28] opcode, [27:24] MM, [23:20] RA, [19:16] RB, [15:12] RD, [15:0] imm.
- RSA, RSB  in  32  register-file read data (RA, RB).
- STAT  in  4  stored condition codes {C,V,N,Z}.
- PC_INC  in  16  current PC + 1.
- ALU_RESULT  out  32  ALU output.
- CC  out  4  new condition codes {C,V,N,Z}.
- STAT_EN  out  1  status-register load enable.
- ALU_OP  out  2  00 idle, 01 register form, 10 immediate form, 11 treated as 00.
- RF_WE, WB_SEL, RD_SEL  out  1 each  RF write enable; writeback select (1 = ALU); dest select (1 = RD, 0 = RB).
- PC_WRITE, PC_SEL, PC_RST  out  1 each  PC load; PC source (1 = BR_ADDR, 0 = PC_INC); PC clear.
- BR_SEL  out  1  1 = absolute target, 0 = relative target.
- BR_ADDR  out  16  branch target.

## Operation
- Opcodes: 0000 NOP; 0001 ALU register (B = RSB); 0010 ALU immediate (B = {16'h0, imm}); 0100 BRA; 0101 BRR; 0110 BNE; 0111 BNR; 1111 HLT; all others execute as NOP.
- ALU function by MM, A = RSA:
  - 0001 ADD.
  - 0010 SUB (A + ~B + 1).
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 NOT A.
  - 0111 A<<1.
  - 1000 A>>1 (logical).
  - Other MM values: result = A.
- ALU_OP 00: ALU_RESULT = RSA; CC still computed but unused.
- CC rules:
  - Z = result==0.
  - N = result[31].
  - C = carry-out for ADD/SUB, else 0.
  - V = signed overflow for ADD/SUB, else 0.
- BR_ADDR:
  - BR_SEL=1: BR_ADDR = imm.
  - BR_SEL=0: BR_ADDR = PC_INC + imm, 16-bit with wrap.
  - BR_SEL = 1 for opcodes 0100 and 0110, else 0. It is combinational from the opcode in every state except START.
- Branch taken:
  - BRA/BRR: (STAT & MM) != 0.
  - BNE/BNR: (STAT & MM) == 0.
- FSM states: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Transitions:
  - START→FETCH→DECODE.
  - DECODE→HALT if opcode 1111, else DECODE→EXECUTE.
  - EXECUTE→MEM→WRITEBACK→FETCH.
  - HALT→HALT.
  - RST from any state → START.
- Outputs are 0 unless listed:
  - START: PC_RST=1.
  - EXECUTE: ALU_OP per opcode (01 for 0001, 10 for 0010); STAT_EN=1 for ALU opcodes.
  - MEM: ALU_OP held.
  - WRITEBACK: ALU_OP held; PC_WRITE=1; PC_SEL = branch taken. For ALU opcodes also RF_WE=1 and WB_SEL=1; RD_SEL=1 for 0001, 0 for 0010.
  - HALT: all outputs 0.

## Timing
- After RST falls: one START cycle, then a 5-cycle instruction (FETCH..WRITEBACK).
- First PC_WRITE occurs in the 6th cycle after RST deasserts.
- ALU and BR paths are purely combinational, with zero latency from their inputs.
- STAT_EN is a single-cycle pulse in EXECUTE. Branch conditions use STAT as sampled in WRITEBACK.
- PC is written only in WRITEBACK, so INSTR is stable for the whole instruction.
- RST during any state, including HALT or mid-instruction, forces START on the next edge. No RF write or PC write occurs in that cycle.

## Test plan
- Reset: hold RST 2 cycles → PC_RST=1 and all other controls 0. Release → states START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK; PC_WRITE=1 only in the 6th cycle.
- ADD reg: INSTR=0x11123000, RSA=0x4D2, RSB=0 → ALU_RESULT=0x4D2, CC=0000, STAT_EN=1 in EXECUTE only. In WRITEBACK: RF_WE=1, WB_SEL=1, RD_SEL=1, PC_SEL=0.
- Flags:
  - SUB 5−5 → result 0, CC=1001.
  - ADD 0x7FFFFFFF+1 → 0x80000000, CC=0110.
  - AND → C=V=0.
- Immediate: INSTR=0x2101FFFF, RSA=1 → ALU_RESULT=0x00010000; RD_SEL=0 in WRITEBACK.
- Branches:
  - BRR (MM=0001, imm=0xFFF0, PC_INC=0x0010), STAT=0001 → BR_ADDR=0x0000, BR_SEL=0, PC_SEL=1.
  - Same BRR with STAT=0000 → PC_SEL=0.
  - BNE (MM=0001, imm=0x0040), STAT=0000 → BR_ADDR=0x0040, BR_SEL=1, PC_SEL=1.
- HLT: INSTR=0xF0000000 → HALT after DECODE; no PC_WRITE for 20 cycles. Assert RST → START with PC_RST=1.
